// File: rtl/regfile_pkg.sv
// Shared register-file constants and the register-index type used by decode and writeback.
package regfile_pkg;

  localparam int NREGS_DEF    = 32;
  localparam int WIDTH_DEF    = 32;
  localparam int ZERO_REG_DEF = 31;
  localparam int XP_REG_DEF   = 30;
  localparam int AW_DEF       = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the scoreboarded register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
);
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic [AW-1:0]    rc;
  logic             ra2sel;
  logic             wasel;
  logic             werf;
  logic             sb_set;
  logic [AW-1:0]    sb_addr;
  logic [WIDTH-1:0] radata;
  logic [WIDTH-1:0] rbdata;
  logic             a_busy;
  logic             b_busy;
  logic             stall;

  modport master (
    output wdata, ra, rb, rc, ra2sel, wasel, werf, sb_set, sb_addr,
    input  radata, rbdata, a_busy, b_busy, stall
  );

  modport slave (
    input  wdata, ra, rb, rc, ra2sel, wasel, werf, sb_set, sb_addr,
    output radata, rbdata, a_busy, b_busy, stall
  );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module regfile_scoreboard #(
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sb_set,
  input  logic [AW-1:0] sb_addr,
  input  logic          werf,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic          busy_a,
  output logic          busy_b
);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  // Clear first, then set: a new producer issued on the writeback cycle keeps the bit.
  always_comb begin
    busy_next = busy_reg;
    if (werf)
      busy_next[waddr] = 1'b0;
    if (sb_set && (sb_addr != ZERO_IDX))
      busy_next[sb_addr] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      busy_reg <= '0;
    else
      busy_reg <= busy_next;
  end

  always_comb begin
    busy_a = busy_reg[addr_a] & ~(BYPASS & werf & (waddr == addr_a));
    busy_b = busy_reg[addr_b] & ~(BYPASS & werf & (waddr == addr_b));
  end

endmodule

// File: rtl/regfile_sb.sv
// NREGS x WIDTH register file with zero register, XP write target, optional bypass and scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int XP_REG   = XP_REG_DEF,
  parameter bit BYPASS   = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int            AW       = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);
  localparam logic [AW-1:0] XP_IDX   = AW'(XP_REG);

  logic [WIDTH-1:0] regs_reg [NREGS];
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    baddr;
  logic             a_busy;
  logic             b_busy;

  assign waddr = bus.wasel  ? XP_IDX : bus.rc;
  assign baddr = bus.ra2sel ? bus.rc : bus.rb;

  // Flop storage rather than RAM: reads are zero-latency and reset must clear everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_reg[i] <= '0;
    end else if (bus.werf && (waddr != ZERO_IDX)) begin
      regs_reg[waddr] <= bus.wdata;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
    if (addr == ZERO_IDX)
      return '0;
    else if (BYPASS && bus.werf && (waddr == addr))
      return bus.wdata;
    else
      return regs_reg[addr];
  endfunction

  always_comb begin
    bus.radata = read_port(bus.ra);
    bus.rbdata = read_port(baddr);
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clock   (clock),
    .reset   (reset),
    .sb_set  (bus.sb_set),
    .sb_addr (bus.sb_addr),
    .werf    (bus.werf),
    .waddr   (waddr),
    .addr_a  (bus.ra),
    .addr_b  (baddr),
    .busy_a  (a_busy),
    .busy_b  (b_busy)
  );

  assign bus.a_busy = a_busy;
  assign bus.b_busy = b_busy;
  assign bus.stall  = a_busy | b_busy;

endmodule
